// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, syncs to vsync, writes pixels linearly into the frame buffer.
// Optional 2x2 decimation when CAM_DECIMATE_EN is defined.
module cam_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int FCNT_W   = 8
) (
    input  logic              p_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              vsync,
    input  logic              href,
    input  logic              pixel_valid,
    input  logic [15:0]       pixel_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic              line_err,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_count
);
    localparam int CNT_W = 16;
`ifdef CAM_DECIMATE_EN
    localparam int FB_PIXELS = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
`endif
    // One bit wider than the address so a full 2^ADDR_W buffer can still be detected as full
    localparam logic [ADDR_W:0]    FB_LIMIT = (ADDR_W + 1)'(FB_PIXELS);
    localparam logic [CNT_W-1:0]   H_COUNT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]   V_COUNT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, DONE} state_t;
    state_t state_reg, state_next;

    logic              vsync_reg, vsync_prev_reg, href_reg, href_prev_reg;
    logic              vsync_rise, href_fall, keep_pixel;
    logic              cont_mode_reg, cont_mode_next;
    logic              stop_pending_reg, stop_pending_next;
    logic [CNT_W-1:0]  x_reg, x_next, y_reg, y_next;
    logic [ADDR_W:0]   addr_reg, addr_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [15:0]       wr_data_reg, wr_data_next;
    logic              line_err_reg, line_err_next, frame_err_reg, frame_err_next;
    logic [FCNT_W-1:0] frame_count_reg, frame_count_next;

    assign vsync_rise = vsync_reg & ~vsync_prev_reg;
    assign href_fall  = href_prev_reg & ~href_reg;

`ifdef CAM_DECIMATE_EN
    assign keep_pixel = ~x_reg[0] & ~y_reg[0];
`else
    assign keep_pixel = 1'b1;
`endif

    always_ff @(posedge p_clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cont_mode_next    = cont_mode_reg;
        stop_pending_next = stop_pending_reg;
        x_next            = x_reg;
        y_next            = y_reg;
        addr_next         = addr_reg;
        wr_en_next        = 1'b0;
        wr_addr_next      = wr_addr_reg;
        wr_data_next      = wr_data_reg;
        line_err_next     = line_err_reg;
        frame_err_next    = frame_err_reg;
        frame_count_next  = frame_count_reg;

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    cont_mode_next = continuous;
                    line_err_next  = 1'b0;
                    frame_err_next = 1'b0;
                    state_next     = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (vsync_rise) begin
                    x_next     = '0;
                    y_next     = '0;
                    addr_next  = '0;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    stop_pending_next = 1'b1;
                end
                if (pixel_valid) begin
                    if (x_reg != CNT_MAX) begin
                        x_next = x_reg + 1'b1;
                    end
                    if (keep_pixel) begin
                        if (addr_reg == FB_LIMIT) begin
                            frame_err_next = 1'b1;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = addr_reg[ADDR_W-1:0];
                            wr_data_next = pixel_data;
                            addr_next    = addr_reg + 1'b1;
                        end
                    end
                end
                // Line and frame checks see the counts including this cycle's pixel/line
                if (href_fall) begin
                    if (x_next != H_COUNT) begin
                        line_err_next = 1'b1;
                    end
                    x_next = '0;
                    if (y_reg != CNT_MAX) begin
                        y_next = y_reg + 1'b1;
                    end
                end
                if (vsync_rise) begin
                    if (y_next != V_COUNT) begin
                        frame_err_next = 1'b1;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_count_next = frame_count_reg + 1'b1;
                if (cont_mode_reg && !stop_pending_reg && !stop) begin
                    x_next     = '0;
                    y_next     = '0;
                    addr_next  = '0;
                    state_next = CAPTURE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            stop_pending_next = 1'b0;
        end
    end

    always_ff @(posedge p_clock) begin
        if (reset) begin
            vsync_reg        <= 1'b0;
            vsync_prev_reg   <= 1'b0;
            href_reg         <= 1'b0;
            href_prev_reg    <= 1'b0;
            cont_mode_reg    <= 1'b0;
            stop_pending_reg <= 1'b0;
            x_reg            <= '0;
            y_reg            <= '0;
            addr_reg         <= '0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
            line_err_reg     <= 1'b0;
            frame_err_reg    <= 1'b0;
            frame_count_reg  <= '0;
        end else begin
            vsync_reg        <= vsync;
            vsync_prev_reg   <= vsync_reg;
            href_reg         <= href;
            href_prev_reg    <= href_reg;
            cont_mode_reg    <= cont_mode_next;
            stop_pending_reg <= stop_pending_next;
            x_reg            <= x_next;
            y_reg            <= y_next;
            addr_reg         <= addr_next;
            wr_en_reg        <= wr_en_next;
            wr_addr_reg      <= wr_addr_next;
            wr_data_reg      <= wr_data_next;
            line_err_reg     <= line_err_next;
            frame_err_reg    <= frame_err_next;
            frame_count_reg  <= frame_count_next;
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign busy         = (state_reg != IDLE);
    assign capture_done = (state_reg == DONE);
    assign line_err     = line_err_reg;
    assign frame_err    = frame_err_reg;
    assign frame_count  = frame_count_reg;
endmodule
